// File: rtl/wb_regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_regfile_pkg
// Description : Shared MIPS32 writeback definitions: WB control bit indices,
//               the hardwired-zero register index and register-file geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_regfile_pkg;

    // Bit positions inside the 2-bit WB control field from MEM/WB
    localparam int         WB_REGWRITE = 1;
    localparam int         WB_MEMTOREG = 0;

    // Architectural register file geometry
    localparam int         REG_DATA_W  = 32;
    localparam int         REG_ADDR_W  = 5;
    localparam int         REG_COUNT   = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage : wb_regfile_pkg
`default_nettype wire

// File: rtl/wb_regfile_regfile_2r1w.sv
`default_nettype none
// ============================================================================
// Module      : regfile_2r1w
// Description : General register array, one synchronous write port and two
//               combinational read ports. Entry 0 is a constant zero and has
//               no storage. All stored entries clear asynchronously on rst.
// Ports       : clk, rst           - clock / async active-high reset
//               i_we, i_waddr,
//               i_wdata            - write port (takes effect at clk rise)
//               i_raddr_a/b        - read addresses
//               o_rdata_a/b        - raw array contents (no bypass)
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_2r1w
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int NREGS  = REG_COUNT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic [REG_ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0]     i_wdata,
    input  logic [REG_ADDR_W-1:0] i_raddr_a,
    input  logic [REG_ADDR_W-1:0] i_raddr_b,
    output logic [DATA_W-1:0]     o_rdata_a,
    output logic [DATA_W-1:0]     o_rdata_b
);

    logic [DATA_W-1:0] w_mem [NREGS];

    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_regs
            if (gi == 0) begin : g_zero
                assign w_mem[gi] = '0;
            end else begin : g_store
                logic [DATA_W-1:0] r_q;

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_q <= '0;
                    end else if (i_we && (i_waddr == REG_ADDR_W'(gi))) begin
                        r_q <= i_wdata;
                    end
                end

                assign w_mem[gi] = r_q;
            end
        end
    endgenerate

    assign o_rdata_a = w_mem[i_raddr_a];
    assign o_rdata_b = w_mem[i_raddr_b];

endmodule : regfile_2r1w
`default_nettype wire

// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
// Module      : wb_regfile
// Description : Writeback stage. Selects memory data or ALU result, commits it
//               to the register file, serves the two ID read ports with
//               same-cycle write-through bypass, exports the writeback bus to
//               the EX forwarding unit and counts register commits.
// Ports       : clk, rst                    - clock / async active-high reset
//               controlIn                   - {RegWrite, MemToReg}
//               memDataIn, aluResultIn,
//               destRegIn                   - MEM/WB payload
//               rsAddr/rtAddr, rsData/rtData - ID read ports
//               wbEn, wbReg, wbData         - forwarding bus
//               commitCount                 - commits since reset (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int NREGS  = REG_COUNT,
    parameter int CNT_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            controlIn,
    input  logic [DATA_W-1:0]     memDataIn,
    input  logic [DATA_W-1:0]     aluResultIn,
    input  logic [REG_ADDR_W-1:0] destRegIn,
    input  logic [REG_ADDR_W-1:0] rsAddr,
    input  logic [REG_ADDR_W-1:0] rtAddr,
    output logic [DATA_W-1:0]     rsData,
    output logic [DATA_W-1:0]     rtData,
    output logic                  wbEn,
    output logic [REG_ADDR_W-1:0] wbReg,
    output logic [DATA_W-1:0]     wbData,
    output logic [CNT_W-1:0]      commitCount
);

    logic              w_wb_en;
    logic [DATA_W-1:0] w_wb_data;
    logic [DATA_W-1:0] w_arr_a;
    logic [DATA_W-1:0] w_arr_b;
    logic [CNT_W-1:0]  r_commit_count;

    // A RegWrite to $0 is treated as no writeback at all: no store, no
    // bypass, no forwarding and no count.
    assign w_wb_en   = controlIn[WB_REGWRITE] && (destRegIn != REG_ZERO);
    assign w_wb_data = controlIn[WB_MEMTOREG] ? memDataIn : aluResultIn;

    assign wbEn   = w_wb_en;
    assign wbReg  = destRegIn;
    assign wbData = w_wb_data;

    regfile_2r1w #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_rf (
        .clk       (clk),
        .rst       (rst),
        .i_we      (w_wb_en),
        .i_waddr   (destRegIn),
        .i_wdata   (w_wb_data),
        .i_raddr_a (rsAddr),
        .i_raddr_b (rtAddr),
        .o_rdata_a (w_arr_a),
        .o_rdata_b (w_arr_b)
    );

    // Read with write-through bypass. Reads are forced to zero during reset
    // so a live MEM/WB payload cannot leak through the bypass path.
    function automatic logic [DATA_W-1:0] f_read(
        input logic                  rst_i,
        input logic [REG_ADDR_W-1:0] addr,
        input logic [DATA_W-1:0]     arr_val,
        input logic                  wb_en,
        input logic [REG_ADDR_W-1:0] wb_reg,
        input logic [DATA_W-1:0]     wb_data
    );
        logic [DATA_W-1:0] v;
        v = arr_val;
        if (rst_i || (addr == REG_ZERO)) begin
            v = '0;
        end else if (wb_en && (addr == wb_reg)) begin
            v = wb_data;
        end
        return v;
    endfunction

    assign rsData = f_read(rst, rsAddr, w_arr_a, w_wb_en, destRegIn, w_wb_data);
    assign rtData = f_read(rst, rtAddr, w_arr_b, w_wb_en, destRegIn, w_wb_data);

    // Commit counter, free-running modulo 2^CNT_W
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_commit_count <= '0;
        end else if (w_wb_en) begin
            r_commit_count <= r_commit_count + CNT_W'(1);
        end
    end

    assign commitCount = r_commit_count;

endmodule : wb_regfile
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_regfile
// Description : Self-checking bench for wb_regfile. Expected values come from
//               a small register/counter model, are queued when stimulus is
//               applied and popped when the DUT output is sampled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_regfile;

    localparam int C_CNT_W = 4;

    logic        clk;
    logic        rst;
    logic [1:0]  controlIn;
    logic [31:0] memDataIn;
    logic [31:0] aluResultIn;
    logic [4:0]  destRegIn;
    logic [4:0]  rsAddr;
    logic [4:0]  rtAddr;
    logic [31:0] rsData;
    logic [31:0] rtData;
    logic        wbEn;
    logic [4:0]  wbReg;
    logic [31:0] wbData;
    logic [C_CNT_W-1:0] commitCount;

    wb_regfile #(
        .DATA_W (32),
        .NREGS  (32),
        .CNT_W  (C_CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .controlIn   (controlIn),
        .memDataIn   (memDataIn),
        .aluResultIn (aluResultIn),
        .destRegIn   (destRegIn),
        .rsAddr      (rsAddr),
        .rtAddr      (rtAddr),
        .rsData      (rsData),
        .rtData      (rtData),
        .wbEn        (wbEn),
        .wbReg       (wbReg),
        .wbData      (wbData),
        .commitCount (commitCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    int          n_total;
    int          n_pass;
    logic [31:0] m_regs [32];
    int          m_cnt;

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        n_total++;
        if (sb.size() == 0) begin
            $error("FAIL scoreboard_empty observed=%h required=<entry>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) n_pass++;
            else $error("FAIL %s observed=%h required=%h", e.tag, obs, e.val);
        end
    endtask

    task automatic drive(input logic [1:0] ctrl, input logic [31:0] mem,
                         input logic [31:0] alu, input logic [4:0] dest,
                         input logic [4:0] rs, input logic [4:0] rt);
        controlIn   = ctrl;
        memDataIn   = mem;
        aluResultIn = alu;
        destRegIn   = dest;
        rsAddr      = rs;
        rtAddr      = rt;
        #1;
    endtask

    // Advance one clock; apply the model commit for whatever is on the bus
    task automatic tick();
        logic [31:0] v;
        v = controlIn[0] ? memDataIn : aluResultIn;
        @(posedge clk);
        if (!rst && controlIn[1] && destRegIn != 5'd0) begin
            m_regs[destRegIn] = v;
            m_cnt = m_cnt + 1;
        end
        #1;
    endtask

    function automatic logic [31:0] m_count();
        return 32'(m_cnt % (1 << C_CNT_W));
    endfunction

    initial begin
        n_total = 0;
        n_pass  = 0;
        m_cnt   = 0;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        rst = 1'b1;
        drive(2'b00, '0, '0, 5'd0, 5'd5, 5'd0);
        repeat (2) @(posedge clk);
        #1;
        push("reset_rs5", 32'h0);            check(rsData);
        push("reset_count", 32'h0);          check(32'(commitCount));
        push("reset_wben", 32'h0);           check(32'(wbEn));
        @(negedge clk);
        rst = 1'b0;
        #1;

        // ALU writeback with same-cycle bypass
        drive(2'b10, 32'h0, 32'hDEADBEEF, 5'd8, 5'd8, 5'd0);
        push("alu_bypass_rs", 32'hDEADBEEF); check(rsData);
        push("alu_wben", 32'h1);             check(32'(wbEn));
        push("alu_wbreg", 32'd8);            check(32'(wbReg));
        push("alu_rt0", 32'h0);              check(rtData);
        tick();
        drive(2'b00, 32'h0, 32'h0, 5'd0, 5'd8, 5'd0);
        push("alu_array_rs", m_regs[8]);     check(rsData);
        push("alu_count", m_count());        check(32'(commitCount));

        // Load writeback selects memory data
        drive(2'b11, 32'hCAFEF00D, 32'h11111111, 5'd31, 5'd0, 5'd31);
        push("load_wbdata", 32'hCAFEF00D);   check(wbData);
        push("load_bypass_rt", 32'hCAFEF00D); check(rtData);
        tick();
        drive(2'b00, 32'h0, 32'h0, 5'd0, 5'd0, 5'd31);
        push("load_array_rt", m_regs[31]);   check(rtData);
        push("load_count", m_count());       check(32'(commitCount));

        // Write to $0 is discarded
        drive(2'b10, 32'h0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0);
        push("zero_wben", 32'h0);            check(32'(wbEn));
        push("zero_rs_same", 32'h0);         check(rsData);
        tick();
        push("zero_rs_after", 32'h0);        check(rsData);
        push("zero_count", m_count());       check(32'(commitCount));

        // RegWrite low: no store, no bypass
        drive(2'b01, 32'h55, 32'h0, 5'd3, 5'd3, 5'd0);
        push("nowr_wben", 32'h0);            check(32'(wbEn));
        push("nowr_wbdata", 32'h55);         check(wbData);
        push("nowr_rs_same", 32'h0);         check(rsData);
        tick();
        push("nowr_rs_after", m_regs[3]);    check(rsData);
        push("nowr_count", m_count());       check(32'(commitCount));

        // Asynchronous reset mid-cycle clears array and counter
        drive(2'b10, 32'h0, 32'h1234, 5'd5, 5'd5, 5'd0);
        tick();
        drive(2'b00, 32'h0, 32'h0, 5'd0, 5'd5, 5'd0);
        push("pre_reset_rs5", 32'h1234);     check(rsData);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_cnt = 0;
        #1;
        push("async_reset_rs5", 32'h0);      check(rsData);
        push("async_reset_count", 32'h0);    check(32'(commitCount));
        // A write presented while in reset must be dropped
        drive(2'b10, 32'h0, 32'h77, 5'd9, 5'd9, 5'd0);
        push("rst_wben_follows", 32'h1);     check(32'(wbEn));
        push("rst_rs9_zero", 32'h0);         check(rsData);
        tick();
        drive(2'b00, 32'h0, 32'h0, 5'd0, 5'd9, 5'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        push("rst_write_aborted", m_regs[9]); check(rsData);
        push("rst_count_aborted", m_count()); check(32'(commitCount));

        // 15 commits bring the 4-bit counter to its maximum
        for (int i = 1; i <= 15; i++) begin
            drive(2'b10, 32'h0, 32'h100 + 32'(i), 5'(i), 5'd0, 5'd0);
            tick();
        end
        drive(2'b00, 32'h0, 32'h0, 5'd0, 5'd12, 5'd15);
        push("loop_reg12", m_regs[12]);      check(rsData);
        push("loop_reg15", m_regs[15]);      check(rtData);
        push("count_max", m_count());        check(32'(commitCount));

        // Dual read of same address through bypass, counter wraps
        drive(2'b10, 32'h0, 32'hA5A5A5A5, 5'd7, 5'd7, 5'd7);
        push("dual_bypass_rs", 32'hA5A5A5A5); check(rsData);
        push("dual_bypass_rt", 32'hA5A5A5A5); check(rtData);
        tick();
        drive(2'b00, 32'h0, 32'h0, 5'd0, 5'd7, 5'd7);
        push("dual_array_rs", m_regs[7]);    check(rsData);
        push("dual_array_rt", m_regs[7]);    check(rtData);
        push("count_wrap", m_count());       check(32'(commitCount));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_wb_regfile
`default_nettype wire

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
Writeback-stage consumer of the MEM/WB pipeline register outputs. It selects the writeback value (memory data or ALU result) and commits it to the 32x32-bit general register file. It also serves the two ID-stage read ports with same-cycle write-through bypass, and exposes the writeback bus to the EX forwarding unit. The block sits between the MEM/WB pipeline register and the ID/EX stage.

Parameters:
DATA_W, 32, register width in bits
NREGS, 32, number of architectural registers (address width = 5)
CNT_W, 32, width of the writeback-commit counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
controlIn  in  2  WB control from MEM/WB; bit1 = RegWrite, bit0 = MemToReg
memDataIn  in  32  load data from MEM/WB
aluResultIn  in  32  ALU result from MEM/WB
destRegIn  in  5  destination register from MEM/WB
rsAddr  in  5  ID read port A address
rtAddr  in  5  ID read port B address
rsData  out  32  read port A data
rtData  out  32  read port B data
wbEn  out  1  writeback active this cycle (to forwarding unit)
wbReg  out  5  writeback destination (to forwarding unit)
wbData  out  32  selected writeback value (to forwarding unit)
commitCount  out  CNT_W  number of register commits since reset

Behaviour:
- Reset (rst=1, asynchronous): all 32 registers := 0; commitCount := 0. While rst is high, no write occurs. rsData/rtData read 0 for every address. wbEn/wbReg/wbData follow the inputs combinationally; the MEM/WB register drives zeros during reset, so these read 0.
- Writeback select (combinational): wbData = controlIn[0] ? memDataIn : aluResultIn; wbReg = destRegIn.
- wbEn = controlIn[1] && (destRegIn != 0). Writes to $0 are discarded.
- Commit: on each rising clk with rst low and wbEn=1, reg[destRegIn] := wbData. Write latency is 1 cycle; the array is updated at the clock edge.
- Read ports (combinational):
  - rsData = 0 if rsAddr == 0.
  - Otherwise rsData = wbData if wbEn && rsAddr == wbReg (write-through bypass).
  - Otherwise rsData = reg[rsAddr].
  - rtData is identical using rtAddr.
- Simultaneous events:
  - Both read ports may hit the same address and both may hit the bypass. Both return the same value.
  - A write with RegWrite=1 to $0 does not bypass and does not count.
- Counter: commitCount increments by 1 on each clock edge where wbEn=1. It wraps modulo 2^CNT_W (0xFFFFFFFF -> 0) with no saturation and no flag.
- Reset mid-operation: asserting rst aborts any write at the coming edge; array and counter clear immediately, independent of clk.
- Register $0 is never stored; it may be implemented as a constant.
- No X propagation: unwritten registers read 0 after reset.

Decomposition:
- Shared package/header (mips32 defines): WB control bit indices (WB_REGWRITE=1, WB_MEMTOREG=0), REG_ZERO=5'd0, DATA_W, register address width.
- One natural sub-module: regfile_2r1w (32x32 array, async reset, one write port, two combinational read ports, $0 hardwired).
- wb_regfile wraps regfile_2r1w and adds the writeback mux, bypass, forwarding outputs and commit counter.

Test Plan:
1. Reset: pulse rst mid-clock-cycle after writing reg[5]=0x1234 -> immediately rsAddr=5 reads 0; commitCount=0.
2. ALU writeback: controlIn=2'b10, aluResultIn=0xDEADBEEF, destRegIn=8.
   - Same cycle: rsAddr=8 -> rsData=0xDEADBEEF (bypass); wbEn=1.
   - After edge, with controlIn=0: rsData=0xDEADBEEF from array; commitCount=1.
3. Load writeback: controlIn=2'b11, memDataIn=0xCAFEF00D, aluResultIn=0x11111111, destRegIn=31 -> wbData=0xCAFEF00D; after edge rtAddr=31 reads 0xCAFEF00D.
4. $0 protection: controlIn=2'b10, destRegIn=0, aluResultIn=0xFFFFFFFF -> wbEn=0; rsAddr=0 reads 0 same cycle and after edge; commitCount unchanged.
5. RegWrite low: controlIn=2'b01, destRegIn=3, memDataIn=0x55 -> reg[3] unchanged (0), no bypass, wbEn=0, count unchanged.
6. Dual read/same address plus counter wrap: force commitCount=0xFFFFFFFF (or CNT_W=4 build after 15 commits), write reg[7]=0xA5A5A5A5 with rsAddr=rtAddr=7 -> both outputs 0xA5A5A5A5; counter wraps to 0.
